traffic_ctrl: RTL and testbench
===============================

// Module: traffic_ctrl
// PURPOSE
//  Parametrised two-road intersection controller on the 1 Hz tick domain.
//  Cycles A-green/A-yellow/all-red/B-green/B-yellow/all-red with per-phase
//  durations, exposes the remaining-time count for a 7-seg display, and
//  supports hold, night flashing-yellow mode and optional pedestrian shortening.
// PARAMETERS
//  CNT_W       5   width of phase timer and remain output
//  T_GREEN_A   10  A-green duration, clk1h cycles (>=1)
//  T_GREEN_B   10  B-green duration (>=1)
//  T_YELLOW    3   yellow duration, both roads (>=1)
//  T_ALLRED    1   all-red clearance duration (>=1)
//  PED_CUT     3   green remaining after a pedestrian request (>=1)
//  LED_ACT_LOW 1   1: light outputs inverted for active-low board LEDs
// PORTS
//  clk1h    in  1      1 Hz tick clock
//  rst_n    in  1      reset, synchronous, active-low
//  en       in  1      1: run; 0: freeze state, timer and outputs
//  night    in  1      level request for flashing-yellow mode
//  ped_req  in  1      pedestrian button, already debounced/synchronised
//  light_a  out 3      road A {red,yellow,green}, polarity per LED_ACT_LOW
//  light_b  out 3      road B {red,yellow,green}
//  remain   out CNT_W  cycles left in current phase (0 on last cycle)
//  phase    out 3      current state encoding
// BEHAVIOUR
//  - States/phase: AG=0 AY=1 AR=2 BG=3 BY=4 BR=5 NT=6; 7 unused -> BR.
//  - Reset: state BR, timer=T_ALLRED-1, both lights red, remain=T_ALLRED-1,
//    phase=5, ped_pend=0, blink=0. First green after reset is AG.
//  - All outputs registered; they reflect current state and timer.
//  - Phase entry loads timer with T-1; timer decrements each en=1 cycle;
//    on timer==0 with en=1 the next phase is entered. A phase of T lasts
//    exactly T cycles.
//  - Order: AG->AY->AR->BG->BY->BR->AG. AR/BR: both roads red.
//  - Lights: AG A=G,B=R; AY A=Y,B=R; BG A=R,B=G; BY A=R,B=Y.
//  - Night: checked only when AR or BR expires; night=1 -> NT, else normal.
//    NT: both roads yellow, blink toggles each cycle (on first NT cycle),
//    remain=0. NT exits when night=0: enter BR (timer T_ALLRED-1), then AG.
//  - en=0: state, timer, blink, outputs hold; ped_req still latched.
//  - Width: CNT_W must hold max(T)-1. Not checked at runtime; integrator
//    responsibility.
//  - Reset mid-phase: returns to reset state on the next clk1h edge;
//    pending request discarded.
// CONFIGURATION
//  TRAFFIC_PED_EN defined: ped_req=1 sets ped_pend. In AG/BG with en=1 and
//    ped_pend=1: if timer>PED_CUT-1, load PED_CUT-1; else timer unaffected;
//    clear ped_pend in both cases. ped_pend persists through other phases and NT.
//    ped_req on the cycle AG/BG expires: transition wins; ped_pend is set
//    and serviced in the next green.
//  TRAFFIC_PED_EN undefined: ped_req ignored, ped_pend constant 0,
//    timing purely parametric.
// TESTING
//  1 reset, defaults, en=1 -> BR 1 cycle, AG 10, AY 3, AR 1, BG 10, BY 3, BR 1;
//    light_a during AG = 3'b110 (active-low G).
//  2 en=0 for 5 cycles mid-AG at remain=6 -> remain/light hold 6 throughout,
//    resumes 5 on re-enable.
//  3 PED_EN, ped_req pulse in AG at remain=8 -> next remain=2, AY after 3 cycles;
//    pulse at remain=1 -> no change, flag cleared.
//  4 PED_EN, ped_req on AY -> BG entry, then remain 2 on BG's 2nd cycle
//    (timer load 9, shortened to 2).
//  5 night=1 during BG -> BG/BY/BR complete, then NT; yellow blinks 1/0;
//    night=0 -> BR 1 cycle -> AG.
//  6 rst_n=0 mid-BY -> next edge: phase=5, both red, remain=T_ALLRED-1.

Source files
------------

// File: rtl/traffic_ctrl.sv
// traffic_ctrl: two-road intersection controller on the 1 Hz tick domain.
// Phase sequence AG -> AY -> AR -> BG -> BY -> BR -> AG, with a night
// flashing-yellow mode entered from the all-red phases. All outputs are
// registered copies of the next state, timer and blink values.
// Optional feature macro: TRAFFIC_PED_EN (pedestrian request shortens green).
`timescale 1ns/1ps
module traffic_ctrl #(
    parameter int CNT_W       = 5,
    parameter int T_GREEN_A   = 10,
    parameter int T_GREEN_B   = 10,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1,
    parameter int PED_CUT     = 3,
    parameter int LED_ACT_LOW = 1
) (
    input  logic             clk1h,
    input  logic             rst_n,
    input  logic             en,
    input  logic             night,
    input  logic             ped_req,
    output logic [2:0]       light_a,
    output logic [2:0]       light_b,
    output logic [CNT_W-1:0] remain,
    output logic [2:0]       phase
);

    typedef enum logic [2:0] {
        S_AG = 3'd0,
        S_AY = 3'd1,
        S_AR = 3'd2,
        S_BG = 3'd3,
        S_BY = 3'd4,
        S_BR = 3'd5,
        S_NT = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LD_GA  = CNT_W'(T_GREEN_A - 1);
    localparam logic [CNT_W-1:0] LD_GB  = CNT_W'(T_GREEN_B - 1);
    localparam logic [CNT_W-1:0] LD_YEL = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_AR  = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] POL      = (LED_ACT_LOW != 0) ? 3'b111 : 3'b000;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             blink_q, blink_d;
    logic [2:0]       light_a_q, light_a_d;
    logic [2:0]       light_b_q, light_b_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [2:0]       phase_q, phase_d;
    logic [2:0]       lamp_a, lamp_b;

`ifdef TRAFFIC_PED_EN
    localparam logic [CNT_W-1:0] LD_PED = CNT_W'(PED_CUT - 1);
    logic ped_pend_q, ped_pend_d;
    logic pend_now;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    // Next state and timer: load T-1 on phase entry, count down, advance at zero
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        blink_d = blink_q;
        if (en) begin
            case (state_q)
                S_AG: if (timer_q == '0) begin state_d = S_AY; timer_d = LD_YEL; end
                      else timer_d = timer_q - ONE;
                S_AY: if (timer_q == '0) begin state_d = S_AR; timer_d = LD_AR; end
                      else timer_d = timer_q - ONE;
                S_AR: if (timer_q == '0) begin
                          if (night) begin state_d = S_NT; timer_d = '0; end
                          else begin state_d = S_BG; timer_d = LD_GB; end
                      end
                      else timer_d = timer_q - ONE;
                S_BG: if (timer_q == '0) begin state_d = S_BY; timer_d = LD_YEL; end
                      else timer_d = timer_q - ONE;
                S_BY: if (timer_q == '0) begin state_d = S_BR; timer_d = LD_AR; end
                      else timer_d = timer_q - ONE;
                S_BR: if (timer_q == '0) begin
                          if (night) begin state_d = S_NT; timer_d = '0; end
                          else begin state_d = S_AG; timer_d = LD_GA; end
                      end
                      else timer_d = timer_q - ONE;
                S_NT: if (!night) begin state_d = S_BR; timer_d = LD_AR; end
                default: begin state_d = S_BR; timer_d = LD_AR; end
            endcase
        end
`ifdef TRAFFIC_PED_EN
        pend_now   = ped_pend_q | ped_req;
        ped_pend_d = pend_now;
        if (en && (state_q == S_AG || state_q == S_BG) && (timer_q != '0) && pend_now) begin
            if (timer_q > LD_PED) timer_d = LD_PED;
            ped_pend_d = 1'b0;
        end
`endif
        if (en) blink_d = (state_d == S_NT) ? ~blink_q : 1'b0;
    end

    // Output decode from the next-state values so registered outputs track the state
    always_comb begin
        lamp_a = LAMP_R;
        lamp_b = LAMP_R;
        case (state_d)
            S_AG: lamp_a = LAMP_G;
            S_AY: lamp_a = LAMP_Y;
            S_BG: lamp_b = LAMP_G;
            S_BY: lamp_b = LAMP_Y;
            S_NT: begin
                lamp_a = blink_d ? LAMP_Y : LAMP_OFF;
                lamp_b = blink_d ? LAMP_Y : LAMP_OFF;
            end
            default: ;
        endcase
        light_a_d = lamp_a ^ POL;
        light_b_d = lamp_b ^ POL;
        remain_d  = (state_d == S_NT) ? '0 : timer_d;
        phase_d   = state_d;
    end

    // State, timer, blink and output registers with synchronous active-low reset
    always_ff @(posedge clk1h) begin
        if (!rst_n) begin
            state_q   <= S_BR;
            timer_q   <= LD_AR;
            blink_q   <= 1'b0;
            light_a_q <= LAMP_R ^ POL;
            light_b_q <= LAMP_R ^ POL;
            remain_q  <= LD_AR;
            phase_q   <= S_BR;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            blink_q   <= blink_d;
            light_a_q <= light_a_d;
            light_b_q <= light_b_d;
            remain_q  <= remain_d;
            phase_q   <= phase_d;
        end
    end

`ifdef TRAFFIC_PED_EN
    // Pedestrian pending flag, latched even while en=0
    always_ff @(posedge clk1h) begin
        if (!rst_n) ped_pend_q <= 1'b0;
        else        ped_pend_q <= ped_pend_d;
    end
`endif

    assign light_a = light_a_q;
    assign light_b = light_b_q;
    assign remain  = remain_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// tb_traffic_ctrl: directed and randomized checks of traffic_ctrl against a
// phase/elapsed-time reference model.
`timescale 1ns/1ps
module tb_traffic_ctrl;

    localparam int CNT_W       = 5;
    localparam int T_GREEN_A   = 10;
    localparam int T_GREEN_B   = 10;
    localparam int T_YELLOW    = 3;
    localparam int T_ALLRED    = 1;
    localparam int PED_CUT     = 3;
    localparam int LED_ACT_LOW = 1;
`ifdef TRAFFIC_PED_EN
    localparam bit PED_ON = 1'b1;
`else
    localparam bit PED_ON = 1'b0;
`endif

    logic             clk1h = 1'b0;
    logic             rst_n, en, night, ped_req;
    logic [2:0]       light_a, light_b, phase;
    logic [CNT_W-1:0] remain;

    int tests  = 0;
    int failed = 0;

    // Reference model: phase index, cycles spent in it, its effective length
    int m_phase, m_elapsed, m_dur, m_nt;
    bit m_pend;

    always #5 clk1h = ~clk1h;

    traffic_ctrl #(
        .CNT_W(CNT_W), .T_GREEN_A(T_GREEN_A), .T_GREEN_B(T_GREEN_B),
        .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED), .PED_CUT(PED_CUT),
        .LED_ACT_LOW(LED_ACT_LOW)
    ) dut (
        .clk1h(clk1h), .rst_n(rst_n), .en(en), .night(night), .ped_req(ped_req),
        .light_a(light_a), .light_b(light_b), .remain(remain), .phase(phase)
    );

    function automatic int durOf(int p);
        case (p)
            0:       return T_GREEN_A;
            1, 4:    return T_YELLOW;
            3:       return T_GREEN_B;
            default: return T_ALLRED;
        endcase
    endfunction

    task automatic enterPhase(int p);
        m_phase   = p;
        m_elapsed = 0;
        m_dur     = durOf(p);
        m_nt      = (p == 6) ? 1 : 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic modelStep();
        bit req;
        bit green;
        if (!rst_n) begin
            enterPhase(5);
            m_pend = 1'b0;
            return;
        end
        req    = PED_ON && (m_pend || ped_req);
        m_pend = req;
        if (!en) return;
        if (m_phase == 6) begin
            if (!night) enterPhase(5);
            else        m_nt++;
            return;
        end
        green = (m_phase == 0) || (m_phase == 3);
        if (m_elapsed == m_dur - 1) begin
            if ((m_phase == 2 || m_phase == 5) && night) enterPhase(6);
            else enterPhase((m_phase + 1) % 6);
        end else begin
            if (green && req) begin
                if (m_dur - 1 - m_elapsed >= PED_CUT) m_dur = m_elapsed + 1 + PED_CUT;
                m_pend = 1'b0;
            end
            m_elapsed++;
        end
    endtask

    function automatic logic [2:0] expLight(bit road_b);
        logic [2:0] v;
        int g;
        g = road_b ? 3 : 0;
        if (m_phase == 6)          v = (m_nt % 2 == 1) ? 3'b010 : 3'b000;
        else if (m_phase == g)     v = 3'b001;
        else if (m_phase == g + 1) v = 3'b010;
        else                       v = 3'b100;
        return (LED_ACT_LOW != 0) ? ~v : v;
    endfunction

    function automatic int expRemain();
        return (m_phase == 6) ? 0 : (m_dur - 1 - m_elapsed);
    endfunction

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkModel();
        checkOutput("model_phase",   phase,   m_phase);
        checkOutput("model_remain",  remain,  expRemain());
        checkOutput("model_light_a", light_a, expLight(1'b0));
        checkOutput("model_light_b", light_b, expLight(1'b1));
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic n, input logic p);
        rst_n   = r;
        en      = e;
        night   = n;
        ped_req = p;
        @(posedge clk1h);
        modelStep();
        #1;
        checkModel();
    endtask

    task automatic waitFor(int p, int r, string tag);
        int g;
        g = 0;
        while (!(int'(phase) == p && (r < 0 || int'(remain) == r)) && g < 80) begin
            applyStimulus(rst_n, en, night, ped_req);
            g++;
        end
        checkOutput(tag, int'(g < 80), 1);
    endtask

    task automatic measurePhase(int p, int len, string tag);
        int cnt;
        int g;
        cnt = 0;
        g   = 0;
        while (int'(phase) == p && g < 40) begin
            cnt++;
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            g++;
        end
        checkOutput(tag, cnt, len);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; night = 1'b0; ped_req = 1'b0;

        $display("[TB] reset state");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_phase",   phase,   5);
        checkOutput("rst_remain",  remain,  T_ALLRED - 1);
        checkOutput("rst_light_a", light_a, 3'b011);
        checkOutput("rst_light_b", light_b, 3'b011);

        $display("[TB] normal cycle durations");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("ag_entry_light_a", light_a, 3'b110);
        checkOutput("ag_entry_remain",  remain,  9);
        measurePhase(0, T_GREEN_A, "len_ag");
        measurePhase(1, T_YELLOW,  "len_ay");
        measurePhase(2, T_ALLRED,  "len_ar");
        measurePhase(3, T_GREEN_B, "len_bg");
        measurePhase(4, T_YELLOW,  "len_by");
        measurePhase(5, T_ALLRED,  "len_br");

        $display("[TB] enable hold");
        waitFor(0, 6, "reach_ag_6");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("hold_remain",  remain,  6);
            checkOutput("hold_light_a", light_a, 3'b110);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("resume_remain", remain, 5);

        $display("[TB] night mode");
        waitFor(3, -1, "reach_bg");
        night = 1'b1;
        waitFor(6, -1, "reach_nt");
        checkOutput("nt1_light_a", light_a, 3'b101);
        checkOutput("nt1_light_b", light_b, 3'b101);
        checkOutput("nt1_remain",  remain,  0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("nt2_light_a", light_a, 3'b111);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("nt3_light_a", light_a, 3'b101);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("nt_exit_phase",   phase,   5);
        checkOutput("nt_exit_light_b", light_b, 3'b011);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("nt_then_ag", phase, 0);

        $display("[TB] reset mid-BY");
        waitFor(4, 1, "reach_by_1");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("midrst_phase",   phase,   5);
        checkOutput("midrst_remain",  remain,  T_ALLRED - 1);
        checkOutput("midrst_light_a", light_a, 3'b011);
        checkOutput("midrst_light_b", light_b, 3'b011);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("midrst_then_ag", phase, 0);

`ifdef TRAFFIC_PED_EN
        $display("[TB] pedestrian shortening");
        waitFor(0, 8, "reach_ag_8");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("ped_cut_remain", remain, PED_CUT - 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("ped_then_ay", phase, 1);
        waitFor(0, 1, "reach_ag_1");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("ped_late_remain", remain, 0);
`endif

        $display("[TB] randomized run");
        begin
            logic r_rst, r_en, r_night, r_ped;
            r_night = 1'b0;
            for (int i = 0; i < 400; i++) begin
                r_rst = ($urandom_range(0, 199) != 0);
                r_en  = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 39) == 0) r_night = ~r_night;
                r_ped = ($urandom_range(0, 9) == 0);
                applyStimulus(r_rst, r_en, r_night, r_ped);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
